// File: rtl/multicycle_adder_if.sv
// Handshake bundle for multicycle_adder: operand side (in_*) and result side (out*).
// MCADD_OVF_EN adds the signed-overflow flag to the result side.
interface multicycle_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             Cout;
`ifdef MCADD_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, in1, in2, Cin, out_ready,
    input  in_ready, out_valid, out, Cout, ovf
  );

  modport slave (
    input  in_valid, in1, in2, Cin, out_ready,
    output in_ready, out_valid, out, Cout, ovf
  );
`else
  modport master (
    output in_valid, in1, in2, Cin, out_ready,
    input  in_ready, out_valid, out, Cout
  );

  modport slave (
    input  in_valid, in1, in2, Cin, out_ready,
    output in_ready, out_valid, out, Cout
  );
`endif
endinterface

// File: rtl/multicycle_adder.sv
// Sequential adder: sums WIDTH-bit operands one CHUNK-bit slice per cycle with a
// registered inter-slice carry. Optional signed overflow output under MCADD_OVF_EN.
module multicycle_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_adder_if.slave bus
);
  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("multicycle_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [IDX_W-1:0] idx_r;
  logic             carry_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             accept_s;
  logic             last_s;
  logic [CHUNK-1:0] a_slice_s;
  logic [CHUNK-1:0] b_slice_s;
  logic [CHUNK:0]   slice_sum_s;
`ifdef MCADD_OVF_EN
  logic             ovf_r;
`endif

  // Current slice sum: the only carry chain in the design is CHUNK+1 bits long.
  always_comb begin
    a_slice_s   = a_r[int'(idx_r)*CHUNK +: CHUNK];
    b_slice_s   = b_r[int'(idx_r)*CHUNK +: CHUNK];
    slice_sum_s = {1'b0, a_slice_s} + {1'b0, b_slice_s} + {{CHUNK{1'b0}}, carry_r};
    last_s      = (idx_r == IDX_W'(N - 1));
  end

  // Next-state decode and operand acceptance.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          accept_s     = 1'b1;
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register with handshake flags registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s == IDLE);
      out_valid_r <= (state_next_s == DONE);
    end
  end

  // Operand capture and slice-by-slice accumulation; results hold outside RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_r   <= '0;
      carry_r <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
`ifdef MCADD_OVF_EN
      ovf_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r     <= bus.in1;
            b_r     <= bus.in2;
            carry_r <= bus.Cin;
            idx_r   <= '0;
          end
        end
        RUN: begin
          sum_r[int'(idx_r)*CHUNK +: CHUNK] <= slice_sum_s[CHUNK-1:0];
          carry_r <= slice_sum_s[CHUNK];
          if (last_s) begin
            idx_r  <= '0;
            cout_r <= slice_sum_s[CHUNK];
`ifdef MCADD_OVF_EN
            // The last slice carries bit WIDTH-1, so its top sum bit is the final sign.
            ovf_r  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                      (slice_sum_s[CHUNK-1] != a_r[WIDTH-1]);
`endif
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        DONE: begin
          idx_r <= '0;
        end
        default: begin
          idx_r <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out       = sum_r;
  assign bus.Cout      = cout_r;
`ifdef MCADD_OVF_EN
  assign bus.ovf       = ovf_r;
`endif

endmodule

// File: doc/multicycle_adder.md
Name: multicycle_adder

Overview:
- Parametrised successor to the team's fixed 16-bit ripple adder.
- Adds two WIDTH-bit operands plus carry-in over WIDTH/CHUNK clock cycles, one CHUNK-bit slice per cycle, using a registered inter-slice carry.
- Trades latency for a short carry chain, so wide adders meet timing.
- Wrapped in a valid/ready handshake on both sides so datapath and control blocks can drop it between pipeline stages.

Parameters:
- WIDTH, 16, operand and result width in bits; must be an exact multiple of CHUNK.
- CHUNK, 4, bits summed per cycle (the width of the combinational carry chain); 1 <= CHUNK <= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- Cin  input  1  carry into bit 0.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result.
- out  output  WIDTH  sum, registered.
- Cout  output  1  carry out of bit WIDTH-1, registered.
- ovf  output  1  signed overflow; present only with MCADD_OVF_EN.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-low on rst_n, sampled on the rising edge of clk.
- Definitions:
  - N = WIDTH/CHUNK.
  - idx counts 0..N-1 and is $clog2(N) bits wide, minimum 1.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, idx=0, internal carry=0.
  - out=0, Cout=0, out_valid=0, ovf=0.
  - in_ready reads 1 on the first cycle after reset.
- IDLE -> RUN on the edge where in_valid && in_ready:
  - in1 and in2 are captured into operand registers.
  - Cin is captured into the carry register.
  - idx=0.
  - in1, in2 and Cin are ignored at all other times; changes during RUN or DONE have no effect.
- RUN, each edge:
  - {c, s} = A[idx*CHUNK +: CHUNK] + B[idx*CHUNK +: CHUNK] + carry, computed at CHUNK+1 bits.
  - out[idx*CHUNK +: CHUNK] <= s; carry <= c; idx <= idx+1.
  - On the edge where idx==N-1: Cout <= c, idx <= 0, state -> DONE.
- Latency:
  - out_valid rises exactly N cycles after the accepting edge.
  - For WIDTH=16, CHUNK=4: accept at edge t, out_valid=1 after edge t+4.
- DONE:
  - out, Cout and ovf are held stable while out_valid && !out_ready.
  - On the edge with out_ready=1: state -> IDLE, out_valid -> 0.
  - out and Cout keep their last values and are not cleared.
- Throughput:
  - One operation per N+2 cycles when out_ready is held high.
  - No accept in the same cycle as a result is taken, because in_ready is 0 in DONE.
- Modular arithmetic:
  - The result is exactly (in1 + in2 + Cin) mod 2^WIDTH, with the carry out on Cout.
  - Wrap-around is not an error.
- Degenerate case CHUNK==WIDTH:
  - N=1: single RUN cycle, latency 1.
- Reset mid-operation (RUN or DONE):
  - Aborts the operation and returns to the reset state.
  - The pending result is discarded and out_valid never pulses.
- Reset has priority over every other event on the same edge.
- Invalid parameters:
  - WIDTH % CHUNK != 0 is a configuration error.
  - An elaboration-time check must fail the build.

Optional Feature:
- Macro name: MCADD_OVF_EN.
- When defined:
  - ovf output port exists.
  - Set on the final RUN edge together with Cout.
  - ovf = (A[WIDTH-1]==B[WIDTH-1]) && (final out[WIDTH-1] != A[WIDTH-1]), with A and B the captured operands.
  - Held in DONE; reset value 0.
- When undefined:
  - ovf port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- Basic sum, WIDTH=16, CHUNK=4: reset, then accept in1=0x1234, in2=0x4321, Cin=0 -> out_valid rises 4 cycles after accept; out=0x5555, Cout=0.
- Full carry ripple across all slices: in1=0xFFFF, in2=0x0001, Cin=0 -> out=0x0000, Cout=1. Then in1=0xFFFF, in2=0x0000, Cin=1 -> out=0x0000, Cout=1.
- Backpressure and input isolation:
  - Accept 0x00FF+0x0F01 and hold out_ready=0 for 5 cycles in DONE.
  - Toggle in1, in2 and in_valid throughout.
  - Expected: out=0x1000 stable, in_ready=0, no second accept.
  - Raise out_ready -> IDLE next cycle, in_ready=1.
- Reset mid-RUN:
  - Accept 0xAAAA+0x5555, then pull rst_n=0 on the 2nd RUN edge.
  - Expected: out=0, Cout=0, out_valid stays 0, in_ready=1 next cycle.
  - A following 0x0001+0x0001 gives out=0x0002.
- Parameter sweep: WIDTH=32 with CHUNK=1, 8 and 32 -> latencies 32, 4 and 1. 0x8000_0000+0x8000_0000 gives out=0, Cout=1 in every case.
- With MCADD_OVF_EN:
  - 0x7FFF+0x0001 -> out=0x8000, ovf=1, Cout=0.
  - 0x8000+0x8000 -> out=0x0000, ovf=1, Cout=1.
  - 0x7FFF+0xFFFF -> out=0x7FFE, ovf=0.
